// File: rtl/serial_receiver.sv
// serial_receiver
//   Receive end of the one-bit-per-clock serial link (pairs with the Transmitter).
//   Waits for a start bit (serIn low while en is high). Shifts in WIDTH data bits
//   LSB first. Checks an optional parity bit and then the stop bit. The result is
//   reported as a one-cycle strobe: valid (with parOut updated), frameErr, or
//   parityErr.
//
// Ports
//   clk        in   1      single clock, all state changes on posedge
//   rst        in   1      synchronous reset, active-low
//   serIn      in   1      serial line, idles high, one bit per clock
//   en         in   1      receive enable; only blocks detection of new start bits
//   parOut     out  WIDTH  last good received word
//   valid      out  1      one-cycle strobe: parOut holds a freshly received word
//   frameErr   out  1      one-cycle strobe: stop bit was 0
//   parityErr  out  1      one-cycle strobe: parity mismatch (word discarded)
//   busy       out  1      high whenever the receiver is not idle
//   Cout       out  1      high in DATA while the last data bit is being sampled

module serial_receiver #(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serIn,
  input  logic             en,
  output logic [WIDTH-1:0] parOut,
  output logic             valid,
  output logic             frameErr,
  output logic             parityErr,
  output logic             busy,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             par_r;
  logic             perr_r;

  // A set result means the received parity bit disagrees with the running data parity.
  function automatic logic parity_mismatch(input logic data_par, input logic par_bit);
    return data_par ^ par_bit ^ (PARITY_ODD != 0);
  endfunction

  // Frame state machine: start detection, data shifting, parity/stop checks, strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      shreg_r   <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      par_r     <= 1'b0;
      perr_r    <= 1'b0;
      parOut    <= {WIDTH{1'b0}};
      valid     <= 1'b0;
      frameErr  <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      // Strobes last exactly one cycle unless STOP raises one below.
      valid     <= 1'b0;
      frameErr  <= 1'b0;
      parityErr <= 1'b0;
      case (state_r)
        IDLE: begin
          // No mid-bit confirmation: any low sample with en set starts a frame.
          if (en && !serIn) begin
            state_r <= DATA;
            cnt_r   <= CW'(WIDTH - 1);
            par_r   <= 1'b0;
            perr_r  <= 1'b0;
          end
        end
        DATA: begin
          shreg_r <= {serIn, shreg_r[WIDTH-1:1]};
          par_r   <= par_r ^ serIn;
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
          end else if (PARITY_EN != 0) begin
            state_r <= PARITY;
          end else begin
            state_r <= STOP;
          end
        end
        PARITY: begin
          perr_r  <= parity_mismatch(par_r, serIn);
          state_r <= STOP;
        end
        STOP: begin
          state_r <= IDLE;
          // A bad stop bit takes priority over a parity error.
          if (!serIn) begin
            frameErr <= 1'b1;
          end else if (perr_r) begin
            parityErr <= 1'b1;
          end else begin
            parOut <= shreg_r;
            valid  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_r != IDLE);
  assign Cout = (state_r == DATA) && (cnt_r == {CW{1'b0}});

endmodule

// File: tb/tb_serial_receiver.sv
module tb_serial_receiver;

  localparam int W  = 8;
  localparam int PE = 1;
  localparam int PO = 0;

  logic         clk;
  logic         rst;
  logic         serIn;
  logic         en;
  logic [W-1:0] parOut;
  logic         valid;
  logic         frameErr;
  logic         parityErr;
  logic         busy;
  logic         Cout;

  serial_receiver #(.WIDTH(W), .PARITY_EN(PE), .PARITY_ODD(PO)) dut (
    .clk(clk), .rst(rst), .serIn(serIn), .en(en), .parOut(parOut),
    .valid(valid), .frameErr(frameErr), .parityErr(parityErr),
    .busy(busy), .Cout(Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome kinds as {valid, frameErr, parityErr}
  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b001;

  typedef struct {
    logic [2:0]   kind;
    logic [W-1:0] word;
    int           when;
  } exp_t;

  exp_t         sb[$];
  int           pc = 0;
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] last_good = '0;

  always @(posedge clk) pc <= pc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, pc);
    end
  endtask

  // Monitor: every strobe pops the scoreboard and is checked for kind, word and timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (valid || frameErr || parityErr)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {valid, frameErr, parityErr}, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {valid, frameErr, parityErr}, e.kind);
        check("parOut", parOut, e.word);
        check("strobe_time", pc, e.when);
      end
    end
  end

  // Drive one bit, let the next posedge sample it, settle just after the edge.
  task automatic bit_out(input logic b);
    serIn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bit_out(1'b1);
  endtask

  // Send one frame and record the outcome the protocol rules dictate.
  task automatic send_frame(input logic [W-1:0] d, input logic bad_par,
                            input logic bad_stop, input logic drop_en);
    exp_t e;
    int   p0;
    logic pbit;
    en = 1'b1;
    bit_out(1'b0);
    p0 = pc;
    check("busy_after_start", busy, 1);
    check("cout_after_start", Cout, 0);
    // Strobe visible in the cycle after the stop edge.
    e.when = p0 + W + 1 + PE;
    if (bad_stop) begin
      e.kind = K_FERR;
      e.word = last_good;
    end else if (PE != 0 && bad_par) begin
      e.kind = K_PERR;
      e.word = last_good;
    end else begin
      e.kind = K_VALID;
      e.word = d;
      last_good = d;
    end
    sb.push_back(e);
    if (drop_en) en = 1'b0;
    for (int i = 0; i < W; i++) begin
      bit_out(d[i]);
      // The counter reaches zero once the second-to-last data bit has been taken.
      check("cout", Cout, (i == W - 2) ? 1 : 0);
    end
    if (PE != 0) begin
      pbit = (^d) ^ (PO != 0) ^ bad_par;
      bit_out(pbit);
    end
    bit_out(~bad_stop);
    serIn = 1'b1;
  endtask

  initial begin
    logic [W-1:0] d;
    rst = 1'b0;
    serIn = 1'b1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_parOut", parOut, 0);
    check("rst_strobes", {valid, frameErr, parityErr}, 0);
    check("rst_busy", busy, 0);
    check("rst_cout", Cout, 0);
    rst = 1'b1;
    idle(2);

    // Directed frames: 0x0A good, bad stop, bad parity, back-to-back 0x0A/0xA5.
    send_frame(8'h0A, 1'b0, 1'b0, 1'b0);
    idle(3);
    send_frame(8'h0A, 1'b0, 1'b1, 1'b0);
    idle(3);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(3);
    send_frame(8'h0A, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Reset during data bit 4 aborts the frame without any strobe.
    en = 1'b1;
    bit_out(1'b0);
    d = 8'h5A;
    for (int i = 0; i < 4; i++) bit_out(d[i]);
    rst = 1'b0;
    bit_out(1'b1);
    rst = 1'b1;
    check("midrst_parOut", parOut, 0);
    check("midrst_strobes", {valid, frameErr, parityErr}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cout", Cout, 0);
    last_good = '0;
    idle(2);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Start bit present while disabled must be ignored.
    en = 1'b0;
    bit_out(1'b0);
    check("en0_busy_a", busy, 0);
    bit_out(1'b0);
    check("en0_busy_b", busy, 0);
    idle(2);
    // Dropping en mid-frame still completes the frame.
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Randomized frames with random corruption, gaps and en drops.
    for (int n = 0; n < 150; n++) begin
      send_frame(W'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 3));
    end

    idle(W + 6);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
